// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity modes and a ceil-log2 helper.
// Used by the receiver and the planned transmitter.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Smallest r with 2**r >= value; a minimum of 1 keeps counters at least 1 bit wide.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL sets the value both flops take in reset (the input's idle level).
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: oversampled start detection with false-start rejection,
// LSB-first deserialisation, optional parity, one or two checked stop bits.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int NB_STOP     = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_tick,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_break,
  output logic               o_busy
);

  localparam int TW = clog2(OVERSAMPLE);
  localparam int BW = clog2(NB_DATA + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(NB_STOP - 1);

  logic rx_s;
  logic [2:0]         state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic               par_q, par_d;
  logic               stop_err_q, stop_err_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;
  logic               brk_q, brk_d;
  logic               busy_q, busy_d;
  logic               tick_mid, sample, final_sample, par_x, par_fail;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  assign tick_mid     = i_tick && (tick_q == TICK_MID);
  assign sample       = i_tick && (tick_q == TICK_END);
  assign final_sample = (state_q == ST_STOP) && sample && (bit_q == STOP_LAST);

  // Parity is judged over data plus the received parity bit.
  assign par_x    = (^shift_q) ^ par_q;
  assign par_fail = (PARITY_MODE == PARITY_EVEN) ? par_x :
                    (PARITY_MODE == PARITY_ODD)  ? ~par_x : 1'b0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!rx_s) state_d = ST_START;
      ST_START:  if (tick_mid) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (sample && (bit_q == DATA_LAST))
                   state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (sample) state_d = ST_STOP;
      ST_STOP:   if (sample && (bit_q == STOP_LAST)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop_err_d = stop_err_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    done_d     = 1'b0;
    busy_d     = (state_d != ST_IDLE);

    if (state_d != state_q)   tick_d = '0;
    else if (i_tick)          tick_d = (tick_q == TICK_END) ? '0 : tick_q + 1'b1;

    // bit_q counts data bits in DATA and stop periods in STOP.
    if (state_d != state_q)   bit_d = '0;
    else if (sample && (state_q == ST_DATA || state_q == ST_STOP)) bit_d = bit_q + 1'b1;

    if (state_q == ST_DATA && sample)   shift_d = {rx_s, shift_q[NB_DATA-1:1]};
    if (state_q == ST_PARITY && sample) par_d = rx_s;

    if (state_q != ST_STOP) stop_err_d = 1'b0;
    else if (sample)        stop_err_d = stop_err_q | ~rx_s;

    if (final_sample) begin
      done_d = 1'b1;
      data_d = shift_q;
      perr_d = par_fail;
      ferr_d = stop_err_q | ~rx_s;
      brk_d  = (stop_err_q | ~rx_s) && (shift_q == '0) && !par_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_err_q <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      stop_err_q <= stop_err_d;
      data_q     <= data_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      busy_q     <= busy_d;
    end
  end

  assign o_data       = data_q;
  assign o_rx_done    = done_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_break      = brk_q;
  assign o_busy       = busy_q;

endmodule
